// File: rtl/pivota_order_engine.sv
// pivota_order_engine
// Accepts one strategy command per handshake, evaluates its comparison on the
// latched operands, and pushes the command's order {side, qty} the requested
// number of times into a show-ahead order FIFO that drains to a valid/ready
// consumer. Keeps wrap-around counts of issued orders and skipped commands.
//
// Build option: define PIVOTA_SIGNED_CMP_EN to compare cmd_a/cmd_b as
// two's-complement signed values for the a>b and a<b conditions. Without it
// the comparison is unsigned. Equality is the same in both builds.

module pivota_order_engine #(
   parameter int DATA_W = 32,
   parameter int QTY_W  = 16,
   parameter int REPS_W = 8,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_side,
   input  logic [1:0]               cmd_cond,
   input  logic [DATA_W-1:0]        cmd_a,
   input  logic [DATA_W-1:0]        cmd_b,
   input  logic [QTY_W-1:0]         cmd_qty,
   input  logic [REPS_W-1:0]        cmd_reps,
   output logic                     ord_valid,
   input  logic                     ord_ready,
   output logic [1:0]               ord_side,
   output logic [QTY_W-1:0]         ord_qty,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]         issued_cnt,
   output logic [CNT_W-1:0]         skipped_cnt
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FCNT_W = PTR_W + 1;
   localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   // Condition evaluation; only the ordering compares change with the build option.
   function automatic logic cond_holds(input logic [1:0]        cond,
                                       input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
      logic res;
      res = 1'b0;
      case (cond)
         2'd0: res = 1'b1;
`ifdef PIVOTA_SIGNED_CMP_EN
         2'd1: res = ($signed(a) > $signed(b));
         2'd2: res = ($signed(a) < $signed(b));
`else
         2'd1: res = (a > b);
         2'd2: res = (a < b);
`endif
         2'd3: res = (a == b);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Control state
   state_t               state_r;
   state_t               state_next_s;
   logic                 cmd_ready_r;

   // Latched command
   logic [1:0]           side_r;
   logic [1:0]           cond_r;
   logic [DATA_W-1:0]    a_r;
   logic [DATA_W-1:0]    b_r;
   logic [QTY_W-1:0]     qty_r;
   logic [REPS_W-1:0]    reps_r;
   logic [REPS_W-1:0]    remaining_r;

   // FIFO
   logic [1:0]           side_mem_r [DEPTH];
   logic [QTY_W-1:0]     qty_mem_r  [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_r;
   logic [PTR_W-1:0]     rd_ptr_r;
   logic [FCNT_W-1:0]    count_r;
   logic [FCNT_W-1:0]    count_next_s;
   logic                 ord_valid_r;

   // Statistics
   logic [CNT_W-1:0]     issued_cnt_r;
   logic [CNT_W-1:0]     skipped_cnt_r;

   // Handshake / control decode
   logic                 accept_s;
   logic                 eval_skip_s;
   logic                 eval_load_s;
   logic                 pop_s;
   logic                 push_allowed_s;
   logic                 push_s;

   assign cmd_ready   = cmd_ready_r;
   assign ord_valid   = ord_valid_r;
   assign fifo_count  = count_r;
   assign issued_cnt  = issued_cnt_r;
   assign skipped_cnt = skipped_cnt_r;

   // Head of FIFO is read straight from storage (show-ahead).
   assign ord_side = side_mem_r[rd_ptr_r];
   assign ord_qty  = qty_mem_r[rd_ptr_r];

   // Pop/push qualification; a full FIFO still takes a push when it pops the same cycle.
   always_comb begin
      pop_s          = ord_valid_r & ord_ready;
      push_allowed_s = (count_r != DEPTH_C) | pop_s;
      eval_skip_s    = (~cond_holds(cond_r, a_r, b_r))
                       | (reps_r == {REPS_W{1'b0}})
                       | (side_r == 2'd0)
                       | (side_r == 2'd3);
   end

   // Next-state and per-state strobes for the IDLE/EVAL/EMIT sequencer.
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      eval_load_s  = 1'b0;
      push_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               accept_s     = 1'b1;
               state_next_s = ST_EVAL;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_EVAL: begin
            if (eval_skip_s) begin
               state_next_s = ST_IDLE;
            end else begin
               eval_load_s  = 1'b1;
               state_next_s = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (push_allowed_s) begin
               push_s = 1'b1;
               if (remaining_r == REPS_W'(1)) begin
                  state_next_s = ST_IDLE;
               end else begin
                  state_next_s = ST_EMIT;
               end
            end else begin
               state_next_s = ST_EMIT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // FIFO occupancy after this cycle's push/pop.
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + FCNT_W'(1);
         2'b01:   count_next_s = count_r - FCNT_W'(1);
         default: count_next_s = count_r;
      endcase
   end

   // State register; cmd_ready is registered from the next state so it tracks IDLE exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cmd_ready_r <= 1'b1;
      end else begin
         state_r     <= state_next_s;
         cmd_ready_r <= (state_next_s == ST_IDLE);
      end
   end

   // Command latch and remaining-repeat counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         side_r      <= 2'd0;
         cond_r      <= 2'd0;
         a_r         <= {DATA_W{1'b0}};
         b_r         <= {DATA_W{1'b0}};
         qty_r       <= {QTY_W{1'b0}};
         reps_r      <= {REPS_W{1'b0}};
         remaining_r <= {REPS_W{1'b0}};
      end else begin
         if (accept_s) begin
            side_r <= cmd_side;
            cond_r <= cmd_cond;
            a_r    <= cmd_a;
            b_r    <= cmd_b;
            qty_r  <= cmd_qty;
            reps_r <= cmd_reps;
         end
         if (eval_load_s) begin
            remaining_r <= reps_r;
         end else if (push_s) begin
            remaining_r <= remaining_r - REPS_W'(1);
         end
      end
   end

   // FIFO storage and pointers; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            side_mem_r[i] <= 2'd0;
            qty_mem_r[i]  <= {QTY_W{1'b0}};
         end
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         count_r     <= {FCNT_W{1'b0}};
         ord_valid_r <= 1'b0;
      end else begin
         if (push_s) begin
            side_mem_r[wr_ptr_r] <= side_r;
            qty_mem_r[wr_ptr_r]  <= qty_r;
            wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r     <= count_next_s;
         ord_valid_r <= (count_next_s != {FCNT_W{1'b0}});
      end
   end

   // Issued/skipped statistics, free-running with wrap-around.
   always_ff @(posedge clk) begin
      if (rst) begin
         issued_cnt_r  <= {CNT_W{1'b0}};
         skipped_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            issued_cnt_r <= issued_cnt_r + CNT_W'(1);
         end
         if ((state_r == ST_EVAL) && eval_skip_s) begin
            skipped_cnt_r <= skipped_cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pivota_order_engine.sv
// Self-checking bench for pivota_order_engine. Expected orders are queued when a
// command is accepted and compared against the FIFO head whenever it is popped.

module tb_pivota_order_engine;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_side;
   logic [1:0]        cmd_cond;
   logic [31:0]       cmd_a;
   logic [31:0]       cmd_b;
   logic [15:0]       cmd_qty;
   logic [7:0]        cmd_reps;
   logic              ord_valid;
   logic              ord_ready;
   logic [1:0]        ord_side;
   logic [15:0]       ord_qty;
   logic [4:0]        fifo_count;
   logic [15:0]       issued_cnt;
   logic [15:0]       skipped_cnt;

   typedef struct packed {
      logic [1:0]  side;
      logic [15:0] qty;
   } ord_t;

   ord_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_issued = 0;
   int   exp_skipped = 0;

   always #5 clk = ~clk;

   pivota_order_engine #(
      .DATA_W(32), .QTY_W(16), .REPS_W(8), .DEPTH(16), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_side(cmd_side), .cmd_cond(cmd_cond),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_qty(cmd_qty), .cmd_reps(cmd_reps),
      .ord_valid(ord_valid), .ord_ready(ord_ready),
      .ord_side(ord_side), .ord_qty(ord_qty),
      .fifo_count(fifo_count),
      .issued_cnt(issued_cnt), .skipped_cnt(skipped_cnt)
   );

   // Reference condition model
   function automatic logic model_cond(input logic [1:0] cond, input logic [31:0] a, input logic [31:0] b);
      case (cond)
         2'd0: return 1'b1;
`ifdef PIVOTA_SIGNED_CMP_EN
         2'd1: return $signed(a) > $signed(b);
         2'd2: return $signed(a) < $signed(b);
`else
         2'd1: return a > b;
         2'd2: return a < b;
`endif
         default: return a == b;
      endcase
   endfunction

   // Scoreboard: compare every popped head against the oldest expected order
   task automatic monitor();
      ord_t e;
      forever begin
         @(negedge clk);
         if (ord_valid === 1'b1 && ord_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL sb_unexpected: got side=%0d qty=%0d, required no order", ord_side, ord_qty);
            end else begin
               e = exp_q.pop_front();
               if ({ord_side, ord_qty} !== e) begin
                  n_errors++;
                  $display("FAIL sb_order: got side=%0d qty=%0d, required side=%0d qty=%0d",
                           ord_side, ord_qty, e.side, e.qty);
               end
            end
         end
      end
   endtask

   // Offer one command (called just after a rising edge); returns just after the accepting edge
   task automatic send_cmd(input logic [1:0] side, input logic [1:0] cond, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] qty, input logic [7:0] reps);
      int   waited;
      ord_t e;
      cmd_side = side; cmd_cond = cond; cmd_a = a; cmd_b = b; cmd_qty = qty; cmd_reps = reps;
      cmd_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
         cmd_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 cmd_valid = 1'b0;
         if (model_cond(cond, a, b) && reps != 8'd0 && (side == 2'd1 || side == 2'd2)) begin
            e.side = side;
            e.qty  = qty;
            for (int i = 0; i < int'(reps); i++) exp_q.push_back(e);
         end else begin
            exp_skipped++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; ord_ready = 1'b0;
      cmd_side = 2'd0; cmd_cond = 2'd0; cmd_a = 32'd0; cmd_b = 32'd0; cmd_qty = 16'd0; cmd_reps = 8'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks += 7;
      if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_cmd_ready: got %b, required 1", cmd_ready); end
      if (ord_valid !== 1'b0) begin n_errors++; $display("FAIL rst_ord_valid: got %b, required 0", ord_valid); end
      if (ord_side !== 2'd0) begin n_errors++; $display("FAIL rst_ord_side: got %0d, required 0", ord_side); end
      if (ord_qty !== 16'd0) begin n_errors++; $display("FAIL rst_ord_qty: got %0d, required 0", ord_qty); end
      if (fifo_count !== 5'd0) begin n_errors++; $display("FAIL rst_fifo_count: got %0d, required 0", fifo_count); end
      if (issued_cnt !== 16'd0) begin n_errors++; $display("FAIL rst_issued: got %0d, required 0", issued_cnt); end
      if (skipped_cnt !== 16'd0) begin n_errors++; $display("FAIL rst_skipped: got %0d, required 0", skipped_cnt); end
   endtask

   task automatic test_single();
      @(posedge clk); #1 ord_ready = 1'b1;
      send_cmd(2'd1, 2'd1, 32'd1800, 32'd100, 16'd15, 8'd1);
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (ord_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_valid: got %b, required 0", ord_valid); end
      end
      @(negedge clk);
      exp_issued += 1;
      n_checks += 2;
      if (ord_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid_n2: got %b, required 1", ord_valid); end
      if (issued_cnt !== 16'(exp_issued)) begin n_errors++; $display("FAIL single_issued: got %0d, required %0d", issued_cnt, exp_issued); end
      @(negedge clk);
      n_checks += 2;
      if (ord_valid !== 1'b0) begin n_errors++; $display("FAIL single_drained: got %b, required 0", ord_valid); end
      if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready: got %b, required 1", cmd_ready); end
   endtask

   task automatic test_skip();
      @(posedge clk); #1;
      send_cmd(2'd2, 2'd2, 32'd1000, 32'd150, 16'd9, 8'd3);
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL skip_busy: got %b, required 0", cmd_ready); end
      @(negedge clk);
      n_checks += 4;
      if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL skip_ready: got %b, required 1", cmd_ready); end
      if (skipped_cnt !== 16'(exp_skipped)) begin n_errors++; $display("FAIL skip_cnt: got %0d, required %0d", skipped_cnt, exp_skipped); end
      if (issued_cnt !== 16'(exp_issued)) begin n_errors++; $display("FAIL skip_issued: got %0d, required %0d", issued_cnt, exp_issued); end
      if (fifo_count !== 5'd0) begin n_errors++; $display("FAIL skip_fifo: got %0d, required 0", fifo_count); end
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1 ord_ready = 1'b1;
      send_cmd(2'd2, 2'd0, 32'd0, 32'd0, 16'd4, 8'd4);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (ord_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid_%0d: got %b, required 1", k, ord_valid); end
      end
      @(negedge clk);
      exp_issued += 4;
      n_checks += 3;
      if (ord_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_end_valid: got %b, required 0", ord_valid); end
      if (issued_cnt !== 16'(exp_issued)) begin n_errors++; $display("FAIL b2b_issued: got %0d, required %0d", issued_cnt, exp_issued); end
      if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready: got %b, required 1", cmd_ready); end
   endtask

   task automatic test_full_stall();
      int waited;
      @(posedge clk); #1 ord_ready = 1'b0;
      send_cmd(2'd1, 2'd3, 32'd115, 32'd115, 16'd115, 8'd20);
      repeat (25) @(negedge clk);
      n_checks += 4;
      if (fifo_count !== 5'd16) begin n_errors++; $display("FAIL full_count: got %0d, required 16", fifo_count); end
      if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL full_stall: got cmd_ready=%b, required 0", cmd_ready); end
      if (issued_cnt !== 16'(exp_issued + 16)) begin n_errors++; $display("FAIL full_issued: got %0d, required %0d", issued_cnt, exp_issued + 16); end
      if (ord_qty !== 16'd115) begin n_errors++; $display("FAIL full_head_qty: got %0d, required 115", ord_qty); end
      @(posedge clk); #1 ord_ready = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!(fifo_count === 5'd0 && cmd_ready === 1'b1) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      exp_issued += 20;
      n_checks += 3;
      if (fifo_count !== 5'd0) begin n_errors++; $display("FAIL full_drain: got %0d after %0d cycles, required 0", fifo_count, waited); end
      if (issued_cnt !== 16'(exp_issued)) begin n_errors++; $display("FAIL full_issued_all: got %0d, required %0d", issued_cnt, exp_issued); end
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL full_leftover: got %0d unpopped, required 0", exp_q.size()); end
   endtask

   task automatic test_cmp_sign();
      @(posedge clk); #1 ord_ready = 1'b1;
      send_cmd(2'd1, 2'd2, 32'hFFFF_FFFF, 32'd1, 16'd7, 8'd1);
      repeat (4) @(negedge clk);
      if (model_cond(2'd2, 32'hFFFF_FFFF, 32'd1)) exp_issued += 1;
      n_checks += 2;
      if (skipped_cnt !== 16'(exp_skipped)) begin n_errors++; $display("FAIL cmp_skipped: got %0d, required %0d", skipped_cnt, exp_skipped); end
      if (issued_cnt !== 16'(exp_issued)) begin n_errors++; $display("FAIL cmp_issued: got %0d, required %0d", issued_cnt, exp_issued); end
   endtask

   task automatic test_invalid();
      @(posedge clk); #1;
      send_cmd(2'd3, 2'd0, 32'd0, 32'd0, 16'd5, 8'd2);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      send_cmd(2'd1, 2'd0, 32'd0, 32'd0, 16'd5, 8'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      send_cmd(2'd0, 2'd0, 32'd0, 32'd0, 16'd5, 8'd1);
      repeat (2) @(negedge clk);
      n_checks += 2;
      if (skipped_cnt !== 16'(exp_skipped)) begin n_errors++; $display("FAIL invalid_skipped: got %0d, required %0d", skipped_cnt, exp_skipped); end
      if (issued_cnt !== 16'(exp_issued)) begin n_errors++; $display("FAIL invalid_issued: got %0d, required %0d", issued_cnt, exp_issued); end
   endtask

   task automatic test_reset_mid_emit();
      @(posedge clk); #1 ord_ready = 1'b0;
      send_cmd(2'd1, 2'd0, 32'd0, 32'd0, 16'd3, 8'd10);
      repeat (5) @(negedge clk);
      n_checks += 2;
      if (fifo_count !== 5'd3) begin n_errors++; $display("FAIL mid_count: got %0d, required 3", fifo_count); end
      if (issued_cnt !== 16'(exp_issued + 3)) begin n_errors++; $display("FAIL mid_issued: got %0d, required %0d", issued_cnt, exp_issued + 3); end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete();
      exp_issued = 0;
      exp_skipped = 0;
      @(negedge clk);
      n_checks += 6;
      if (ord_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_valid: got %b, required 0", ord_valid); end
      if (fifo_count !== 5'd0) begin n_errors++; $display("FAIL mid_rst_count: got %0d, required 0", fifo_count); end
      if (issued_cnt !== 16'd0) begin n_errors++; $display("FAIL mid_rst_issued: got %0d, required 0", issued_cnt); end
      if (skipped_cnt !== 16'd0) begin n_errors++; $display("FAIL mid_rst_skipped: got %0d, required 0", skipped_cnt); end
      if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL mid_rst_ready: got %b, required 1", cmd_ready); end
      if (ord_qty !== 16'd0) begin n_errors++; $display("FAIL mid_rst_qty: got %0d, required 0", ord_qty); end
      // Engine must work normally after the mid-stream reset
      @(posedge clk); #1 ord_ready = 1'b1;
      send_cmd(2'd2, 2'd0, 32'd0, 32'd0, 16'd33, 8'd2);
      repeat (6) @(negedge clk);
      exp_issued += 2;
      n_checks += 3;
      if (issued_cnt !== 16'(exp_issued)) begin n_errors++; $display("FAIL post_rst_issued: got %0d, required %0d", issued_cnt, exp_issued); end
      if (fifo_count !== 5'd0) begin n_errors++; $display("FAIL post_rst_count: got %0d, required 0", fifo_count); end
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL post_rst_leftover: got %0d unpopped, required 0", exp_q.size()); end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_single();
      test_skip();
      test_back_to_back();
      test_full_stall();
      test_cmp_sign();
      test_invalid();
      test_reset_mid_emit();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
